// File: rtl/sine_trace_engine.sv
// Overlays NUM_CH horizontally scrolling sine traces on the VGA pixel stream.
// Two-stage pixel pipeline. Per-channel phase and draw mode update at frame_start.
module sine_trace_engine #(
  parameter int unsigned X_BITS     = 10,
  parameter int unsigned Y_BITS     = 10,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned LUT_DEPTH  = 16,
  parameter int unsigned AMP        = 32,
  parameter int unsigned BASE_Y     = 120,
  parameter int unsigned CH_SPACING = 160,
  parameter int unsigned THICK      = 1,
  parameter logic [23:0] CH_COLOR   = 24'b111111_000011_001100_110000,
  parameter logic [5:0]  BG_COLOR   = 6'b000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [X_BITS-1:0]     x,
  input  logic [Y_BITS-1:0]     y,
  input  logic                  frame_active,
  input  logic                  frame_start,
  input  logic                  scroll_en,
  input  logic [1:0]            mode,
  input  logic [8*NUM_CH-1:0]   ch_speed,
  output logic [1:0]            r,
  output logic [1:0]            g,
  output logic [1:0]            b,
  output logic                  pix_active
);

  localparam int unsigned KW = $clog2(LUT_DEPTH);
  localparam int unsigned P  = KW + 2;
  localparam int unsigned CW = Y_BITS + 2;

  localparam logic [1:0] MODE_TRACE = 2'd0;
  localparam logic [1:0] MODE_FILL  = 2'd1;
  localparam logic [1:0] MODE_DASH  = 2'd2;

  localparam logic signed [CW-1:0] THK = CW'(THICK);

  // Integer Taylor series of AMP*sin(pi*i/(2*LUT_DEPTH)) in Q28, rounded to nearest.
  function automatic int unsigned lut_val(input int unsigned i);
    longint ang;
    longint term;
    longint acc;
    ang  = (longint'(843314857) * longint'(i)) / longint'(2 * LUT_DEPTH);
    term = ang;
    acc  = ang;
    for (int n = 1; n <= 7; n++) begin
      term = (term * ang) >>> 28;
      term = (term * ang) >>> 28;
      term = -(term / longint'(4 * n * n + 2 * n));
      acc  = acc + term;
    end
    return 32'((acc * longint'(AMP) + (longint'(1) <<< 27)) >>> 28);
  endfunction

  if (BASE_Y < AMP + THICK) begin : g_chk_base
    $error("sine_trace_engine: BASE_Y must be >= AMP + THICK");
  end
  if (NUM_CH < 1 || NUM_CH > 4) begin : g_chk_ch
    $error("sine_trace_engine: NUM_CH must be 1..4");
  end
  if (LUT_DEPTH < 4 || (LUT_DEPTH & (LUT_DEPTH - 1)) != 0) begin : g_chk_lut
    $error("sine_trace_engine: LUT_DEPTH must be a power of two >= 4");
  end
  if (AMP < 1 || AMP > 127) begin : g_chk_amp
    $error("sine_trace_engine: AMP must be 1..127");
  end

  logic [7:0] w_lut [LUT_DEPTH];
  for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_lut
    localparam int unsigned LV = lut_val(i);
    assign w_lut[i] = 8'(LV);
  end

  logic [P-1:0]        r_phase [NUM_CH];
  logic [1:0]          r_mode;
  logic [P-1:0]        w_idx   [NUM_CH];
  logic [KW-1:0]       r_s1_k  [NUM_CH];
  logic [1:0]          r_s1_qd [NUM_CH];
  logic [Y_BITS-1:0]   r_s1_y;
  logic                r_s1_x2;
  logic                r_s1_act;
  logic [1:0]          r_s1_mode;
  logic [5:0]          r_rgb;
  logic                r_act;
  logic [NUM_CH-1:0]   w_hit;
  logic [5:0]          w_rgb;
  logic signed [CW-1:0] w_y;
  logic                w_unused_x;

  assign w_unused_x = ^x;
  assign w_y        = CW'(r_s1_y);

  // Phase and mode change only at frame_start; the pixel sampled in that cycle still sees the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) r_phase[c] <= '0;
      r_mode <= '0;
    end else if (frame_start) begin
      r_mode <= mode;
      if (scroll_en) begin
        for (int c = 0; c < NUM_CH; c++)
          r_phase[c] <= r_phase[c] + P'($signed(ch_speed[8*c +: 8]));
      end
    end
  end

  // Stage 1: wave index per channel plus the pixel context it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_s1_k[c]  <= '0;
        r_s1_qd[c] <= '0;
      end
      r_s1_y    <= '0;
      r_s1_x2   <= 1'b0;
      r_s1_act  <= 1'b0;
      r_s1_mode <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_s1_k[c]  <= w_idx[c][KW-1:0];
        r_s1_qd[c] <= w_idx[c][P-1:P-2];
      end
      r_s1_y    <= y;
      r_s1_x2   <= x[2];
      r_s1_act  <= frame_active;
      r_s1_mode <= r_mode;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic signed [CW-1:0] BASE = CW'(BASE_Y + c * CH_SPACING);
    logic [KW-1:0]        w_k;
    logic signed [CW-1:0] w_mag;
    logic signed [CW-1:0] w_s;
    logic signed [CW-1:0] w_curve;
    logic signed [CW-1:0] w_diff;
    logic signed [CW-1:0] w_lo;
    logic signed [CW-1:0] w_hi;
    logic                 w_near;
    logic                 w_fill;

    assign w_idx[c] = P'(x) + r_phase[c];
    // Odd quadrants mirror the quarter wave: ~k == LUT_DEPTH-1-k for a power-of-two depth.
    assign w_k     = r_s1_qd[c][0] ? ~r_s1_k[c] : r_s1_k[c];
    assign w_mag   = CW'(w_lut[w_k]);
    assign w_s     = r_s1_qd[c][1] ? -w_mag : w_mag;
    assign w_curve = BASE - w_s;
    assign w_diff  = w_y - w_curve;
    assign w_near  = (w_diff >= -THK) && (w_diff <= THK);
    assign w_lo    = (w_curve < BASE) ? w_curve : BASE;
    assign w_hi    = (w_curve < BASE) ? BASE : w_curve;
    assign w_fill  = (w_y >= w_lo) && (w_y <= w_hi);
    assign w_hit[c] = (r_s1_mode == MODE_TRACE) ? w_near :
                      (r_s1_mode == MODE_FILL)  ? w_fill :
                      (r_s1_mode == MODE_DASH)  ? (w_near & ~r_s1_x2) : 1'b0;
  end

  // Lowest-index hitting channel wins.
  always_comb begin
    w_rgb = BG_COLOR;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (w_hit[c]) w_rgb = CH_COLOR[6*c +: 6];
    end
    if (!r_s1_act) w_rgb = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb <= '0;
      r_act <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_act <= r_s1_act;
    end
  end

  assign r          = r_rgb[5:4];
  assign g          = r_rgb[3:2];
  assign b          = r_rgb[1:0];
  assign pix_active = r_act;

endmodule

// File: tb/tb_sine_trace_engine.sv
// Directed bench for sine_trace_engine: default 2-channel instance plus a
// 4-channel, zero-spacing instance for the priority check.
module tb_sine_trace_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        frame_active;
  logic        frame_start;
  logic        scroll_en;
  logic [1:0]  mode;
  logic [15:0] ch_speed;
  logic [31:0] ch_speed4;
  logic [1:0]  r, g, b;
  logic [1:0]  r4, g4, b4;
  logic        pix_active, pix_active4;

  int checks = 0;
  int passes = 0;

  localparam logic [6:0] RED = 7'b110000_1;
  localparam logic [6:0] GRN = 7'b001100_1;
  localparam logic [6:0] BG  = 7'b000000_1;
  localparam logic [6:0] OFF = 7'b000000_0;

  sine_trace_engine dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .frame_active(frame_active), .frame_start(frame_start),
    .scroll_en(scroll_en), .mode(mode), .ch_speed(ch_speed),
    .r(r), .g(g), .b(b), .pix_active(pix_active)
  );

  sine_trace_engine #(.NUM_CH(4), .CH_SPACING(0)) dut4 (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .frame_active(frame_active), .frame_start(frame_start),
    .scroll_en(scroll_en), .mode(mode), .ch_speed(ch_speed4),
    .r(r4), .g(g4), .b(b4), .pix_active(pix_active4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Present one pixel, hold it through the 2-cycle pipeline, check the default instance.
  task automatic pix(input int px, input int py, input logic fa,
                     input logic [6:0] exp, input string tag);
    x = 10'(px);
    y = 10'(py);
    frame_active = fa;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk(tag, {r, g, b, pix_active}, exp);
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; x = '0; y = 10'd120; frame_active = 1'b1; frame_start = 1'b0;
    scroll_en = 1'b0; mode = 2'd0; ch_speed = '0; ch_speed4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {r, g, b, pix_active}, OFF);
    chk("reset_out4", {r4, g4, b4, pix_active4}, OFF);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("release_1cyc", {r, g, b, pix_active}, OFF);
    @(posedge clk); #1;
    chk("release_2cyc", {r, g, b, pix_active}, RED);

    // Phase 0, trace mode
    pix(0, 121, 1'b1, RED, "thick_edge");
    pix(0, 122, 1'b1, BG,  "thick_out");
    pix(0, 123, 1'b1, BG,  "bg_y123");
    pix(16, 88, 1'b1, RED, "q1_peak");
    pix(48, 152, 1'b1, RED, "q3_trough");
    pix(32, 120, 1'b1, RED, "q2_zero");
    pix(16, 120, 1'b1, BG,  "q1_baseline_bg");
    pix(0, 280, 1'b1, GRN, "ch1_green");
    pix(0, 120, 1'b0, OFF, "inactive");

    // Scrolling
    ch_speed = 16'h0010; scroll_en = 1'b1;
    pulse();
    pix(0, 88, 1'b1, RED, "scroll16");
    pulse();
    pix(0, 120, 1'b1, RED, "scroll32");
    pix(0, 88, 1'b1, BG,  "scroll32_old");
    ch_speed = 16'h00F0;
    pulse();
    pix(0, 88, 1'b1, RED, "neg_scroll16");
    pulse();
    pix(0, 120, 1'b1, RED, "neg_scroll0");
    ch_speed = 16'h003C;
    pulse();
    pix(0, 129, 1'b1, RED, "phase60");
    ch_speed = 16'h0008;
    pulse();
    pix(0, 108, 1'b1, RED, "wrap_phase4");
    pix(0, 120, 1'b1, BG,  "wrap_phase4_bg");
    ch_speed = 16'h00FC;
    pulse();
    pix(0, 120, 1'b1, RED, "back_to_0");

    // Pixel in the frame_start cycle uses the old phase; next pixel the new one
    ch_speed = 16'h0010;
    x = 10'd0; y = 10'd120; frame_active = 1'b1; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0; x = 10'd0; y = 10'd88;
    @(posedge clk); #1;
    chk("same_cycle_old_phase", {r, g, b, pix_active}, RED);
    @(posedge clk); #1;
    chk("next_pixel_new_phase", {r, g, b, pix_active}, RED);

    scroll_en = 1'b0;
    repeat (3) pulse();
    pix(0, 88, 1'b1, RED, "scroll_hold");
    pix(0, 120, 1'b1, BG,  "scroll_hold_bg");
    scroll_en = 1'b1; ch_speed = 16'h00F0;
    pulse();
    scroll_en = 1'b0;
    pix(0, 120, 1'b1, RED, "restore_phase0");

    // Mode latch
    mode = 2'd1;
    pix(16, 100, 1'b1, BG, "mode_mid_frame");
    pulse();
    pix(16, 100, 1'b1, RED, "fill_inside");
    pix(16, 88, 1'b1, RED,  "fill_curve_edge");
    pix(16, 120, 1'b1, RED, "fill_baseline");
    pix(16, 87, 1'b1, BG,   "fill_above");
    pix(16, 121, 1'b1, BG,  "fill_below");
    mode = 2'd2;
    pulse();
    pix(4, 120, 1'b1, BG,  "dash_gap");
    pix(0, 120, 1'b1, RED, "dash_on");
    mode = 2'd3;
    pulse();
    pix(0, 120, 1'b1, BG, "mode3_none");
    mode = 2'd0;
    pulse();

    // Priority across four overlapping channels
    pix(0, 120, 1'b1, RED, "prio_dut2ch");
    chk("prio_4ch", {r4, g4, b4, pix_active4}, RED);

    // Mid-frame reset clears phase and mode
    ch_speed = 16'h0010; scroll_en = 1'b1; mode = 2'd3;
    pulse();
    scroll_en = 1'b0;
    pix(0, 120, 1'b1, BG, "pre_reset_mode3");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_out", {r, g, b, pix_active}, OFF);
    chk("rst_mid_out4", {r4, g4, b4, pix_active4}, OFF);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_release_1", {r, g, b, pix_active}, OFF);
    @(posedge clk); #1;
    chk("rst_mid_release_2", {r, g, b, pix_active}, RED);
    chk("rst_mid_release_4ch", {r4, g4, b4, pix_active4}, RED);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
